// File: rtl/register_writeback_pkg.sv
// Shared register-file constants used by the write-back path.
package register_writeback_pkg;

  // These values match the register file's write port.
  localparam int               REG_ADDR_WIDTH = 5;
  localparam int               REG_DATA_WIDTH = 32;
  localparam logic [4:0]       REG_ZERO       = 5'd0;

endpackage

// File: rtl/writeback_queue.sv
// In-order circular buffer with two enqueue ports (first is older) and one
// pop per cycle whenever it holds anything.
module writeback_queue
  import register_writeback_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int CNT_W     = PTR_W + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_first,
  input  logic [ADDR_WIDTH-1:0] push_first_register,
  input  logic [DATA_WIDTH-1:0] push_first_data,
  input  logic                  push_second,
  input  logic [ADDR_WIDTH-1:0] push_second_register,
  input  logic [DATA_WIDTH-1:0] push_second_data,
  output logic [ADDR_WIDTH-1:0] head_register,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [CNT_W-1:0]      count,
  output logic [PTR_W-1:0]      tail_ptr,
  output logic [ADDR_WIDTH-1:0] entry_register [DEPTH],
  output logic [DATA_WIDTH-1:0] entry_data     [DEPTH]
);

  logic [ADDR_WIDTH-1:0] reg_q  [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;
  logic [CNT_W-1:0]      count_q;

  logic                  pop;
  logic [1:0]            n_push;
  logic [PTR_W-1:0]      second_slot;
  logic [CNT_W-1:0]      count_next;

  // Pop is unconditional while occupied: the register file never stalls.
  always_comb begin
    pop         = (count_q != '0);
    n_push      = {1'b0, push_first} + {1'b0, push_second};
    second_slot = push_first ? tail_q + PTR_W'(1) : tail_q;
    count_next  = count_q - CNT_W'(pop) + CNT_W'(n_push);
  end

  // Entry storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push_first) begin
      reg_q[tail_q]  <= push_first_register;
      data_q[tail_q] <= push_first_data;
    end
    if (push_second) begin
      reg_q[second_slot]  <= push_second_register;
      data_q[second_slot] <= push_second_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(pop);
      tail_q  <= tail_q + PTR_W'(n_push);
      count_q <= count_next;
    end
  end

  assign head_register  = reg_q[head_q];
  assign head_data      = data_q[head_q];
  assign count          = count_q;
  assign tail_ptr       = tail_q;
  assign entry_register = reg_q;
  assign entry_data     = data_q;

endmodule

// File: rtl/register_writeback.sv
// Write-back initiator for the register file: arbitrates load and ALU
// results into an in-order queue, drains one write per cycle and offers
// forwarding of values accepted but not yet committed.
module register_writeback
  import register_writeback_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     memValid,
  input  logic [ADDR_WIDTH-1:0]    memRegister,
  input  logic [DATA_WIDTH-1:0]    memData,
  output logic                     memReady,
  input  logic                     aluValid,
  input  logic [ADDR_WIDTH-1:0]    aluRegister,
  input  logic [DATA_WIDTH-1:0]    aluData,
  output logic                     aluReady,
  output logic                     regWrite,
  output logic [ADDR_WIDTH-1:0]    writeRegister,
  output logic [DATA_WIDTH-1:0]    writeData,
  input  logic [ADDR_WIDTH-1:0]    lookupRegister,
  output logic                     lookupHit,
  output logic [DATA_WIDTH-1:0]    lookupData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] ZERO_REG = ADDR_WIDTH'(REG_ZERO);

  logic [ADDR_WIDTH-1:0] head_register;
  logic [DATA_WIDTH-1:0] head_data;
  logic [CNT_W-1:0]      count_q;
  logic [PTR_W-1:0]      tail_ptr;
  logic [ADDR_WIDTH-1:0] entry_register [DEPTH];
  logic [DATA_WIDTH-1:0] entry_data     [DEPTH];

  logic                  mem_push;
  logic                  alu_push;
  logic [CNT_W:0]        alu_demand;
  logic [PTR_W-1:0]      scan_idx;

  // Ready ignores the same-cycle pop; the ALU port reserves room for a
  // simultaneous load, which is the older instruction.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == CNT_W'(DEPTH));
    alu_demand = {1'b0, count_q} + (CNT_W+1)'(memValid);
    memReady   = !full;
    aluReady   = (alu_demand < (CNT_W+1)'(DEPTH));
    mem_push   = memValid && memReady && (memRegister != ZERO_REG);
    alu_push   = aluValid && aluReady && (aluRegister != ZERO_REG);
  end

  writeback_queue #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_queue (
    .clock                (clock),
    .reset                (reset),
    .push_first           (mem_push),
    .push_first_register  (memRegister),
    .push_first_data      (memData),
    .push_second          (alu_push),
    .push_second_register (aluRegister),
    .push_second_data     (aluData),
    .head_register        (head_register),
    .head_data            (head_data),
    .count                (count_q),
    .tail_ptr             (tail_ptr),
    .entry_register       (entry_register),
    .entry_data           (entry_data)
  );

  // Head entry drives the write port; outputs are held at zero when idle.
  always_comb begin
    regWrite      = !empty;
    writeRegister = empty ? '0 : head_register;
    writeData     = empty ? '0 : head_data;
  end

  // Youngest-match scan from tail-1 back towards head; the first hit wins.
  always_comb begin
    lookupHit  = 1'b0;
    lookupData = '0;
    scan_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = tail_ptr - PTR_W'(i + 1);
      if (!lookupHit && (CNT_W'(i) < count_q) &&
          (lookupRegister != ZERO_REG) &&
          (entry_register[scan_idx] == lookupRegister)) begin
        lookupHit  = 1'b1;
        lookupData = entry_data[scan_idx];
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_register_writeback.sv
// Directed bench for register_writeback with a write-port scoreboard.
module tb_register_writeback;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          memValid = 1'b0;
  logic [AW-1:0] memRegister = '0;
  logic [DW-1:0] memData = '0;
  logic          memReady;
  logic          aluValid = 1'b0;
  logic [AW-1:0] aluRegister = '0;
  logic [DW-1:0] aluData = '0;
  logic          aluReady;
  logic          regWrite;
  logic [AW-1:0] writeRegister;
  logic [DW-1:0] writeData;
  logic [AW-1:0] lookupRegister = '0;
  logic          lookupHit;
  logic [DW-1:0] lookupData;
  logic [2:0]    count;
  logic          empty;
  logic          full;

  register_writeback #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset),
    .memValid(memValid), .memRegister(memRegister), .memData(memData), .memReady(memReady),
    .aluValid(aluValid), .aluRegister(aluRegister), .aluData(aluData), .aluReady(aluReady),
    .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
    .lookupRegister(lookupRegister), .lookupHit(lookupHit), .lookupData(lookupData),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;
  int  mc       = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected entry.
  always @(negedge clock) begin
    if (!reset) begin
      if (regWrite) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=r%0d/0x%0h required=no write at %0t",
                   writeRegister, writeData, $time);
        end else begin
          mon_e = sb.pop_front();
          chk("writeRegister", 64'(writeRegister), 64'(mon_e.r));
          chk("writeData", 64'(writeData), 64'(mon_e.d));
        end
      end else begin
        chk("idle_writeRegister", 64'(writeRegister), 64'd0);
        chk("idle_writeData", 64'(writeData), 64'd0);
      end
    end
  end

  // One cycle of stimulus; readiness and occupancy are predicted by the model count.
  task automatic step(input logic mv, input logic [AW-1:0] mr, input logic [DW-1:0] md,
                      input logic av, input logic [AW-1:0] ar, input logic [DW-1:0] ad,
                      output logic macc, output logic aacc);
    int n;
    memValid = mv; memRegister = mr; memData = md;
    aluValid = av; aluRegister = ar; aluData = ad;
    @(negedge clock);
    chk("count", 64'(count), 64'(mc));
    chk("memReady", 64'(memReady), 64'(mc != DEPTH));
    chk("aluReady", 64'(aluReady), 64'((mc + int'(mv)) < DEPTH));
    chk("empty", 64'(empty), 64'(mc == 0));
    chk("full", 64'(full), 64'(mc == DEPTH));
    macc = mv && (mc != DEPTH);
    aacc = av && ((mc + int'(mv)) < DEPTH);
    n = 0;
    if (macc && mr != 0) begin sb.push_back('{r: mr, d: md}); n++; end
    if (aacc && ar != 0) begin sb.push_back('{r: ar, d: ad}); n++; end
    mc = mc - ((mc != 0) ? 1 : 0) + n;
    @(posedge clock);
    #1;
    memValid = 1'b0;
    aluValid = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a, b;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0, a, b);
  endtask

  task automatic look(input logic [AW-1:0] r, input logic hit, input logic [DW-1:0] d);
    lookupRegister = r;
    #1;
    chk($sformatf("lookupHit_r%0d", r), 64'(lookupHit), 64'(hit));
    chk($sformatf("lookupData_r%0d", r), 64'(lookupData), 64'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ma, aa;
    int   mi, ai, stall_cyc;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_regWrite", 64'(regWrite), 64'd0);
    chk("rst_lookupHit", 64'(lookupHit), 64'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single ALU write r3 <- 0xAA, visible on the port the next cycle
    step(1'b0, '0, '0, 1'b1, 5'd3, 32'h0000_00AA, ma, aa);
    chk("lat_regWrite", 64'(regWrite), 64'd1);
    chk("lat_writeRegister", 64'(writeRegister), 64'd3);
    chk("lat_writeData", 64'(writeData), 64'hAA);
    look(5'd3, 1'b1, 32'hAA);
    idle(2);

    // Both sources every cycle, held until accepted
    mi = 1; ai = 5; stall_cyc = -1;
    for (int cyc = 0; cyc < 20 && (mi <= 4 || ai <= 8); cyc++) begin
      step(mi <= 4, AW'(mi), DW'(32'h100 + mi), ai <= 8, AW'(ai), DW'(32'h100 + ai), ma, aa);
      if (ai <= 8 && !aa && stall_cyc < 0) stall_cyc = cyc;
      if (ma) mi++;
      if (aa) ai++;
    end
    chk("burst_mem_all", 64'(mi), 64'd5);
    chk("burst_alu_all", 64'(ai), 64'd9);
    chk("burst_alu_first_stall", 64'(stall_cyc), 64'd2);
    idle(6);
    chk("burst_drained", 64'(sb.size()), 64'd0);

    // Forwarding: two r7 entries, the younger one wins
    step(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, ma, aa);
    look(5'd7, 1'b1, 32'h22);
    look(5'd0, 1'b0, 32'h0);
    look(5'd9, 1'b0, 32'h0);
    idle(1);
    look(5'd7, 1'b1, 32'h22);
    idle(1);
    look(5'd7, 1'b0, 32'h0);
    idle(1);

    // Register-0 destinations handshake but never enqueue
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF, ma, aa);
    chk("r0_alu_accepted", 64'(aa), 64'd1);
    chk("r0_count", 64'(count), 64'd0);
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, '0, ma, aa);
    chk("r0_regWrite", 64'(regWrite), 64'd0);
    idle(2);

    // Wrap-around: ten back-to-back single writes
    for (int i = 1; i <= 10; i++)
      step(1'b0, '0, '0, 1'b1, AW'(i), DW'(32'h200 + i), ma, aa);
    idle(3);
    chk("wrap_drained", 64'(sb.size()), 64'd0);

    // Async reset with three entries pending
    step(1'b1, 5'd1, 32'h31, 1'b1, 5'd2, 32'h32, ma, aa);
    step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h34, ma, aa);
    chk("pre_rst_count", 64'(count), 64'd3);
    look(5'd3, 1'b1, 32'h33);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_regWrite", 64'(regWrite), 64'd0);
    chk("arst_writeRegister", 64'(writeRegister), 64'd0);
    chk("arst_writeData", 64'(writeData), 64'd0);
    chk("arst_lookupHit", 64'(lookupHit), 64'd0);
    sb.delete();
    mc = 0;
    @(posedge clock);
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    idle(4);
    step(1'b0, '0, '0, 1'b1, 5'd6, 32'h66, ma, aa);
    idle(2);

    chk("final_scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
